// File: rtl/spi_master.sv
// SPI mode-0 master: one fixed-width frame per start pulse, MSB first,
// with programmable half-period and registered sclk/ss/mosi outputs.
module spi_master #(
    parameter int FRAME_W = 32,
    parameter int DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIV_W-1:0]   clk_div,
    input  logic [FRAME_W-1:0] tx_data,
    output logic [FRAME_W-1:0] rx_data,
    output logic               busy,
    output logic               done,
    output logic               sclk,
    output logic               ss,
    output logic               mosi,
    input  logic               miso
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   hc, hc_d;
    logic [DIV_W-1:0]   clk_div_q, clk_div_q_d;
    logic [FRAME_W-1:0] tx_sh, tx_sh_d;
    logic [FRAME_W-1:0] rx_sh, rx_sh_d;
    logic [FRAME_W-1:0] rx_data_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic               sclk_d, ss_d, mosi_d, busy_d, done_d;
    logic               terminal;

    assign terminal = (hc == clk_div_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hc        <= '0;
            clk_div_q <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            hc        <= hc_d;
            clk_div_q <= clk_div_q_d;
            tx_sh     <= tx_sh_d;
            rx_sh     <= rx_sh_d;
            rx_data   <= rx_data_d;
            bit_cnt   <= bit_cnt_d;
            sclk      <= sclk_d;
            ss        <= ss_d;
            mosi      <= mosi_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        hc_d        = hc + 1'b1;
        clk_div_q_d = clk_div_q;
        tx_sh_d     = tx_sh;
        rx_sh_d     = rx_sh;
        rx_data_d   = rx_data;
        bit_cnt_d   = bit_cnt;
        sclk_d      = sclk;
        ss_d        = ss;
        mosi_d      = mosi;
        busy_d      = busy;
        done_d      = 1'b0;

        unique case (state)
            IDLE: begin
                hc_d   = '0;
                ss_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    tx_sh_d     = tx_data;
                    clk_div_q_d = clk_div;
                    rx_sh_d     = '0;
                    bit_cnt_d   = '0;
                    ss_d        = 1'b0;
                    mosi_d      = tx_data[FRAME_W-1];
                    busy_d      = 1'b1;
                    state_d     = LEAD;
                end
            end
            LEAD: begin
                if (terminal) begin
                    hc_d      = '0;
                    sclk_d    = 1'b1;
                    rx_sh_d   = {rx_sh[FRAME_W-2:0], miso};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = XFER;
                end
            end
            XFER: begin
                // The low phase after the last falling edge is spent here,
                // so TRAIL starts one full half-period after that edge.
                if (terminal) begin
                    hc_d = '0;
                    if (sclk) begin
                        sclk_d  = 1'b0;
                        tx_sh_d = tx_sh << 1;
                        mosi_d  = tx_sh[FRAME_W-2];
                    end else if (bit_cnt == CNT_W'(FRAME_W)) begin
                        state_d = TRAIL;
                    end else begin
                        sclk_d    = 1'b1;
                        rx_sh_d   = {rx_sh[FRAME_W-2:0], miso};
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (terminal) begin
                    hc_d      = '0;
                    ss_d      = 1'b1;
                    rx_data_d = rx_sh;
                    done_d    = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (terminal) begin
                    hc_d    = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and tied-miso frames, start
// re-pulse, clk_div change mid-frame and asynchronous reset mid-transfer.
module tb_spi_master;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  clk_div;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic        busy;
    logic        done;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        loop_en;

    int num_checks;
    int num_fails;

    logic first_ss, first_busy, first_mosi, mosi_one;
    int   done_cyc, busy_low_cyc, rises, first_rise_cyc, ss_low;
    int   min_ph, max_ph, done_cnt;

    assign miso = loop_en ? mosi : 1'b1;

    spi_master #(
        .FRAME_W(32),
        .DIV_W  (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .clk_div(clk_div),
        .tx_data(tx_data),
        .rx_data(rx_data),
        .busy   (busy),
        .done   (done),
        .sclk   (sclk),
        .ss     (ss),
        .mosi   (mosi),
        .miso   (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one frame from the start pulse until busy drops, gathering timing
    // statistics; optionally re-pulses start and/or changes clk_div at mid_at.
    task automatic applyStimulus(input logic [31:0] tx, input logic [7:0] div,
                                 input int mid_at, input logic mid_start,
                                 input logic [31:0] mid_tx, input logic [7:0] mid_div);
        int   last_tog;
        logic prev_sclk;
        bit   finished;
        tx_data = tx;
        clk_div = div;
        start   = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
        first_ss       = ss;
        first_busy     = busy;
        first_mosi     = mosi;
        mosi_one       = mosi;
        done_cyc       = -1;
        busy_low_cyc   = -1;
        first_rise_cyc = -1;
        rises          = 0;
        ss_low         = ss ? 0 : 1;
        min_ph         = 99999;
        max_ph         = 0;
        done_cnt       = 0;
        last_tog       = -1;
        prev_sclk      = sclk;
        finished       = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            if (cyc == mid_at) begin
                clk_div = mid_div;
                if (mid_start) begin
                    tx_data = mid_tx;
                    start   = 1'b1;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (!ss) ss_low++;
            if (mosi) mosi_one = 1'b1;
            if (sclk != prev_sclk) begin
                if (sclk) begin
                    rises++;
                    if (first_rise_cyc < 0) first_rise_cyc = cyc;
                end
                if (last_tog >= 0) begin
                    if (cyc - last_tog < min_ph) min_ph = cyc - last_tog;
                    if (cyc - last_tog > max_ph) max_ph = cyc - last_tog;
                end
                last_tog = cyc;
            end
            prev_sclk = sclk;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (!busy) begin
                busy_low_cyc = cyc;
                finished     = 1'b1;
            end
        end
        checkOutput("frame_timeout", finished, 1'b1);
    endtask

    initial begin
        int   r;
        logic prev;
        num_checks = 0;
        num_fails  = 0;
        rst     = 1'b0;
        start   = 1'b0;
        clk_div = 8'd0;
        tx_data = 32'h0;
        loop_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ss", ss, 1'b1);
        checkOutput("rst_sclk", sclk, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_ss", ss, 1'b1);
        checkOutput("idle_sclk", sclk, 1'b0);
        checkOutput("idle_mosi", mosi, 1'b0);
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_done", done, 1'b0);
        checkOutput("idle_rx", rx_data, 32'h0);

        // Loopback at H=1
        loop_en = 1'b1;
        applyStimulus(32'hA5A50F0F, 8'd0, 0, 1'b0, 32'h0, 8'd0);
        checkOutput("lb_first_ss", first_ss, 1'b0);
        checkOutput("lb_first_busy", first_busy, 1'b1);
        checkOutput("lb_first_mosi", first_mosi, 1'b1);
        checkOutput("lb_first_rise", first_rise_cyc, 1);
        checkOutput("lb_done_cyc", done_cyc, 66);
        checkOutput("lb_rises", rises, 32);
        checkOutput("lb_ss_low", ss_low, 66);
        checkOutput("lb_min_ph", min_ph, 1);
        checkOutput("lb_max_ph", max_ph, 1);
        checkOutput("lb_done_cnt", done_cnt, 1);
        checkOutput("lb_busy_fall", busy_low_cyc, 67);
        checkOutput("lb_rx", rx_data, 32'hA5A50F0F);

        // miso tied high, tx all zero, H=4
        loop_en = 1'b0;
        applyStimulus(32'h00000000, 8'd3, 0, 1'b0, 32'h0, 8'd0);
        checkOutput("m1_first_mosi", first_mosi, 1'b0);
        checkOutput("m1_first_rise", first_rise_cyc, 4);
        checkOutput("m1_done_cyc", done_cyc, 264);
        checkOutput("m1_ss_low", ss_low, 264);
        checkOutput("m1_rises", rises, 32);
        checkOutput("m1_min_ph", min_ph, 4);
        checkOutput("m1_max_ph", max_ph, 4);
        checkOutput("m1_mosi_zero", mosi_one, 1'b0);
        checkOutput("m1_busy_fall", busy_low_cyc, 268);
        checkOutput("m1_rx", rx_data, 32'hFFFFFFFF);

        // start re-pulsed mid-XFER with other data, H=2
        loop_en = 1'b1;
        applyStimulus(32'h12345678, 8'd1, 30, 1'b1, 32'hDEADBEEF, 8'd1);
        checkOutput("rp_done_cnt", done_cnt, 1);
        checkOutput("rp_done_cyc", done_cyc, 132);
        checkOutput("rp_rises", rises, 32);
        checkOutput("rp_busy_fall", busy_low_cyc, 134);
        checkOutput("rp_rx", rx_data, 32'h12345678);

        // accepted in the very first busy-low cycle
        applyStimulus(32'h0F0F00FF, 8'd0, 0, 1'b0, 32'h0, 8'd0);
        checkOutput("b2b_first_ss", first_ss, 1'b0);
        checkOutput("b2b_first_busy", first_busy, 1'b1);
        checkOutput("b2b_first_mosi", first_mosi, 1'b0);
        checkOutput("b2b_done_cyc", done_cyc, 66);
        checkOutput("b2b_rx", rx_data, 32'h0F0F00FF);

        // clk_div changed 3 -> 0 mid-frame
        applyStimulus(32'h3C3CC3C3, 8'd3, 100, 1'b0, 32'h0, 8'd0);
        checkOutput("dc_min_ph", min_ph, 4);
        checkOutput("dc_max_ph", max_ph, 4);
        checkOutput("dc_done_cyc", done_cyc, 264);
        checkOutput("dc_busy_fall", busy_low_cyc, 268);
        checkOutput("dc_rx", rx_data, 32'h3C3CC3C3);
        applyStimulus(32'hC0FFEE11, 8'd0, 0, 1'b0, 32'h0, 8'd0);
        checkOutput("dc_next_done", done_cyc, 66);
        checkOutput("dc_next_ph", max_ph, 1);
        checkOutput("dc_next_rx", rx_data, 32'hC0FFEE11);

        // asynchronous reset during bit 10
        tx_data = 32'hFFFF0000;
        clk_div = 8'd1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r     = 0;
        prev  = sclk;
        for (int c = 0; c < 400 && r < 10; c++) begin
            @(posedge clk); #1;
            if (sclk && !prev) r++;
            prev = sclk;
        end
        checkOutput("ar_reach_bit10", r, 10);
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_ss", ss, 1'b1);
        checkOutput("ar_sclk", sclk, 1'b0);
        checkOutput("ar_busy", busy, 1'b0);
        checkOutput("ar_mosi", mosi, 1'b0);
        checkOutput("ar_rx", rx_data, 32'h0);
        @(posedge clk); #1;
        rst      = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        checkOutput("ar_no_done", done_cnt, 0);
        checkOutput("ar_idle_busy", busy, 1'b0);
        checkOutput("ar_idle_rx", rx_data, 32'h0);

        // normal operation after reset
        applyStimulus(32'h80000001, 8'd0, 0, 1'b0, 32'h0, 8'd0);
        checkOutput("post_done_cyc", done_cyc, 66);
        checkOutput("post_rx", rx_data, 32'h80000001);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master that generates `sclk`, `ss` and `mosi` and captures `miso` for one fixed-width frame per request. It sits directly upstream of `spi_slave`: in the controller-side design and in the `spi_slave` testbench it drives the slave's serial pins. Host logic loads the frame, pulses `start`, and receives the captured frame with a one-cycle `done`.

## Interface
- `FRAME_W`, 32: bits per frame. Must be ≥ 2. Shifted MSB first.
- `DIV_W`, 8: width of `clk_div`.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  transfer request; sampled only in IDLE.
- `clk_div`  in  DIV_W  half-period select: H = `clk_div`+1 clk cycles. Latched at start.
- `tx_data`  in  FRAME_W  frame to send. Latched at start.
- `rx_data`  out  FRAME_W  last captured frame; updated only with `done`.
- `busy`  out  1  high from the cycle after the accepted start through the end of GAP.
- `done`  out  1  one-cycle pulse when the frame completes.
- `sclk`  out  1  serial clock, idle low. Registered.
- `ss`  out  1  slave select, active low, idle high. Registered.
- `mosi`  out  1  serial data out. Registered; 0 when idle.
- `miso`  in  1  serial data in.

## Operation
- FSM states: IDLE, LEAD, XFER, TRAIL, GAP.
- Half-period counter `hc` counts 0..`clk_div_q`. It clears on every state entry and on every `sclk` toggle. "Terminal" means `hc == clk_div_q`.
- **IDLE:** `ss`=1, `sclk`=0, `mosi`=0, `busy`=0.
  - On `start`=1: latch `tx_data` into `tx_sh` and `clk_div` into `clk_div_q`.
  - Drive `ss`=0, `mosi`=`tx_data[FRAME_W-1]`, `busy`=1, and go to LEAD.
- **LEAD:** hold `sclk`=0 for H cycles. At terminal: `sclk`→1, sample `miso` into `rx_sh` LSB (shift left), then go to XFER.
- **XFER:** at each terminal, toggle `sclk`.
  - 1→0 (falling): shift `tx_sh` left and drive `mosi` from the new MSB.
  - 0→1 (rising): shift `miso` into `rx_sh`. `miso` is sampled on the same `clk` edge that raises `sclk`.
  - Bit counter (width clog2(FRAME_W+1)) counts rising edges.
  - After the falling edge that follows the FRAME_W-th rising edge: go to TRAIL.
- **TRAIL:** `sclk`=0, `ss`=0 for H cycles. At terminal: `ss`→1, `rx_data`←`rx_sh`, `done`=1 for that cycle, then go to GAP.
- **GAP:** `ss`=1 for H cycles (minimum deselect time for the slave's `ss` edge detection). At terminal go to IDLE; `busy`=0 from the next cycle.
- `start` outside IDLE is ignored. It is not queued.
- Changes to `tx_data` and `clk_div` after acceptance have no effect on the frame in flight.
- **Reset (asynchronous, any state):** `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, FSM=IDLE, all counters and shift registers 0. No partial `done` is produced.

## Timing
- Reset values: `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0.
- `start` sampled high at edge n (IDLE): `ss`=0, `busy`=1 and `mosi`=frame MSB are all visible after edge n.
- First `sclk` rise: H cycles after `ss` falls.
- `sclk` high and low phases: exactly H cycles each, giving exactly FRAME_W rising edges per frame.
- `ss` low duration: (2·FRAME_W+2)·H cycles.
- `done`: coincides with the cycle `ss` returns high, (2·FRAME_W+2)·H cycles after edge n.
- `busy` falls H cycles after `done`. A new `start` is accepted in the first cycle `busy`=0.
- `mosi` changes only on falling `sclk` (and on the `ss` fall). It is stable for 2H cycles around each rising edge.
- When driving `spi_slave`, `clk_div` must be ≥ 3 (H ≥ 4) to cover the slave's input synchronizer. `clk_div`=0 is functionally legal, for example in loopback.

## Test plan
- Loopback (`miso`=`mosi`), FRAME_W=32, `clk_div`=0, `tx_data`=0xA5A50F0F: `rx_data`=0xA5A50F0F. `done` 66 cycles after the start edge. Exactly 32 `sclk` rises. `ss` low for 66 cycles.
- `miso` tied 1, `clk_div`=3, `tx_data`=0: `rx_data`=0xFFFFFFFF. `ss` low for 264 cycles. Every `sclk` phase is 4 cycles. `mosi` stays 0.
- `start` re-pulsed mid-XFER with a different `tx_data`: no second transfer, one `done` only, first frame unchanged. Then a `start` in the first cycle `busy`=0 is accepted immediately.
- `rst` asserted during XFER bit 10: `ss`=1, `sclk`=0, `busy`=0 asynchronously. No `done`. `rx_data` reads 0.
- `clk_div` changed from 3 to 0 during a transfer: phases stay at 4 cycles until GAP ends. The next frame uses H=1.
- Integration with `spi_slave` at `clk_div`=3: a write frame followed by a read frame of the same address returns the written data on `rx_data`.
